// File: rtl/serial_parity_checker_pkg.sv
// Shared types and constants for the serial parity checker and anything that
// needs to predict its parity results.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_e;

    localparam logic PARITY_EVEN     = 1'b0;
    localparam logic PARITY_ODD_MODE = 1'b1;

    // Parity bit a sender should append to a (zero-extended) data word.
    function automatic logic expected_parity(input logic [31:0] word, input logic mode);
        return (^word) ^ mode;
    endfunction

endpackage

// File: rtl/serial_parity_checker_if.sv
// Serial bit stream in, reassembled frame and status out.
interface serial_parity_checker_if #(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 8
);
    logic                 clear;
    logic                 bit_in;
    logic                 bit_valid;
    logic [DATA_BITS-1:0] data_out;
    logic                 frame_done;
    logic                 parity_err;
    logic [CNT_W-1:0]     err_count;
    logic                 busy;

    modport master (
        output clear, bit_in, bit_valid,
        input  data_out, frame_done, parity_err, err_count, busy
    );

    modport slave (
        input  clear, bit_in, bit_valid,
        output data_out, frame_done, parity_err, err_count, busy
    );
endinterface

// File: rtl/serial_parity_checker_sat_counter.sv
// Up-counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, then saturating increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {W{1'b0}};
        end else if (inc && (count_q != MAX_VAL)) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/serial_parity_checker.sv
// Reassembles an LSB-first serial frame (data bits then one parity bit),
// checks its parity and keeps a saturating count of bad frames.
module serial_parity_checker
    import parity_pkg::*;
#(
    parameter int   DATA_BITS  = 8,
    parameter logic PARITY_ODD = 1'b0,
    parameter int   CNT_W      = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    serial_parity_checker_if.slave  bus
);
    localparam int                IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     cnt_q,   cnt_d;
    logic                 par_q,   par_d;
    logic [DATA_BITS-1:0] data_q,  data_d;
    logic                 done_q,  done_d;
    logic                 perr_q,  perr_d;
    logic                 busy_q;
    logic                 err_s;

    assign err_s = par_q ^ bus.bit_in ^ PARITY_ODD;

    // Frame FSM: clear discards the partial frame and drops any bit this cycle.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        data_d  = data_q;
        done_d  = 1'b0;
        perr_d  = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
            shift_d = {DATA_BITS{1'b0}};
            cnt_d   = {IDX_W{1'b0}};
            par_d   = 1'b0;
        end else if (bus.bit_valid) begin
            case (state_q)
                IDLE: begin
                    shift_d    = {DATA_BITS{1'b0}};
                    shift_d[0] = bus.bit_in;
                    cnt_d      = IDX_W'(1);
                    par_d      = bus.bit_in;
                    state_d    = DATA;
                end
                DATA: begin
                    shift_d[cnt_q] = bus.bit_in;
                    par_d          = par_q ^ bus.bit_in;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = {IDX_W{1'b0}};
                        state_d = PARITY;
                    end else begin
                        cnt_d   = cnt_q + IDX_W'(1);
                        state_d = DATA;
                    end
                end
                PARITY: begin
                    data_d  = shift_q;
                    done_d  = 1'b1;
                    perr_d  = err_s;
                    cnt_d   = {IDX_W{1'b0}};
                    par_d   = 1'b0;
                    state_d = IDLE;
                end
                default: begin
                    cnt_d   = {IDX_W{1'b0}};
                    par_d   = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= {DATA_BITS{1'b0}};
            cnt_q   <= {IDX_W{1'b0}};
            par_q   <= 1'b0;
            data_q  <= {DATA_BITS{1'b0}};
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            data_q  <= data_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (bus.clear),
        .inc     (done_d & perr_d),
        .count   (bus.err_count)
    );

    assign bus.data_out   = data_q;
    assign bus.frame_done = done_q;
    assign bus.parity_err = perr_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_serial_parity_checker.sv
// Drives three checker instances (even, odd, even with 2-bit counter) and
// compares every cycle against a frame-level reference model.
module tb_serial_parity_checker;
    logic clock;
    logic reset_n;
    logic bit_in;
    logic valid;
    logic clear;
    int   sel;
    int   total;
    int   bad;

    serial_parity_checker_if #(.DATA_BITS(8), .CNT_W(8)) if_even ();
    serial_parity_checker_if #(.DATA_BITS(8), .CNT_W(8)) if_odd ();
    serial_parity_checker_if #(.DATA_BITS(8), .CNT_W(2)) if_sat ();

    assign if_even.bit_in    = bit_in;
    assign if_odd.bit_in     = bit_in;
    assign if_sat.bit_in     = bit_in;
    assign if_even.bit_valid = valid & (sel == 0);
    assign if_odd.bit_valid  = valid & (sel == 1);
    assign if_sat.bit_valid  = valid & (sel == 2);
    assign if_even.clear     = clear & (sel == 0);
    assign if_odd.clear      = clear & (sel == 1);
    assign if_sat.clear      = clear & (sel == 2);

    serial_parity_checker #(.DATA_BITS(8), .PARITY_ODD(1'b0), .CNT_W(8)) u_even (
        .clock(clock), .reset_n(reset_n), .bus(if_even));
    serial_parity_checker #(.DATA_BITS(8), .PARITY_ODD(1'b1), .CNT_W(8)) u_odd (
        .clock(clock), .reset_n(reset_n), .bus(if_odd));
    serial_parity_checker #(.DATA_BITS(8), .PARITY_ODD(1'b0), .CNT_W(2)) u_sat (
        .clock(clock), .reset_n(reset_n), .bus(if_sat));

    always #5 clock = ~clock;

    logic [7:0] obs_data;
    logic       obs_done;
    logic       obs_perr;
    logic [7:0] obs_cnt;
    logic       obs_busy;

    // Route the selected instance's outputs to the comparison points.
    always_comb begin
        obs_data = 8'h00;
        obs_done = 1'b0;
        obs_perr = 1'b0;
        obs_cnt  = 8'h00;
        obs_busy = 1'b0;
        case (sel)
            0: begin
                obs_data = if_even.data_out; obs_done = if_even.frame_done;
                obs_perr = if_even.parity_err; obs_cnt = if_even.err_count;
                obs_busy = if_even.busy;
            end
            1: begin
                obs_data = if_odd.data_out; obs_done = if_odd.frame_done;
                obs_perr = if_odd.parity_err; obs_cnt = if_odd.err_count;
                obs_busy = if_odd.busy;
            end
            default: begin
                obs_data = if_sat.data_out; obs_done = if_sat.frame_done;
                obs_perr = if_sat.parity_err; obs_cnt = {6'b000000, if_sat.err_count};
                obs_busy = if_sat.busy;
            end
        endcase
    end

    // Reference model: bits received so far in the current frame, plus results.
    int         nbits  [3];
    logic [7:0] word   [3];
    logic [7:0] m_data [3];
    logic       m_done [3];
    logic       m_perr [3];
    int         m_cnt  [3];
    logic       m_odd  [3] = '{1'b0, 1'b1, 1'b0};
    int         m_max  [3] = '{255, 255, 3};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            nbits[k] = 0; word[k] = 8'h00; m_data[k] = 8'h00;
            m_done[k] = 1'b0; m_perr[k] = 1'b0; m_cnt[k] = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_done"}, {31'd0, obs_done}, {31'd0, m_done[sel]});
        check({tag, "_perr"}, {31'd0, obs_perr}, {31'd0, m_perr[sel]});
        check({tag, "_data"}, {24'd0, obs_data}, {24'd0, m_data[sel]});
        check({tag, "_cnt"},  {24'd0, obs_cnt},  m_cnt[sel]);
        check({tag, "_busy"}, {31'd0, obs_busy}, {31'd0, (nbits[sel] != 0)});
    endtask

    // One clock cycle of stimulus on the selected instance, then model update and check.
    task automatic step(input logic v, input logic b, input logic clr);
        logic e;
        bit_in = b; valid = v; clear = clr;
        @(posedge clock);
        #1;
        valid = 1'b0; clear = 1'b0;
        m_done[sel] = 1'b0;
        m_perr[sel] = 1'b0;
        if (clr) begin
            nbits[sel] = 0;
            m_cnt[sel] = 0;
        end else if (v) begin
            if (nbits[sel] < 8) begin
                word[sel][nbits[sel]] = b;
                nbits[sel]++;
            end else begin
                e = (($countones(word[sel]) % 2) == 1) ^ b ^ m_odd[sel];
                m_data[sel] = word[sel];
                m_done[sel] = 1'b1;
                m_perr[sel] = e;
                if (e && (m_cnt[sel] < m_max[sel])) m_cnt[sel]++;
                nbits[sel] = 0;
            end
        end
        check_outputs("step");
    endtask

    task automatic send_frame(input logic [7:0] w, input logic p, input int maxgap);
        for (int i = 0; i < 9; i++) begin
            repeat ($urandom_range(maxgap, 0)) step(1'b0, 1'($urandom % 2), 1'b0);
            step(1'b1, (i < 8) ? w[i] : p, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] w;
        clock = 1'b0; reset_n = 1'b0; bit_in = 1'b0; valid = 1'b0; clear = 1'b0;
        sel = 0; total = 0; bad = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #1;
            check_outputs("reset");
        end
        reset_n = 1'b1;

        // Even parity, good then bad 0xA5.
        sel = 0;
        send_frame(8'hA5, 1'b0, 0);
        check("a5_good_data", {24'd0, obs_data}, 32'h0000_00A5);
        check("a5_good_perr", {31'd0, obs_perr}, 32'd0);
        send_frame(8'hA5, 1'b1, 0);
        check("a5_bad_perr", {31'd0, obs_perr}, 32'd1);
        check("a5_bad_cnt", {24'd0, obs_cnt}, 32'd1);

        // Back-to-back frames with no idle cycle.
        send_frame(8'h3C, 1'b0, 0);
        check("b2b_first", {24'd0, obs_data}, 32'h0000_003C);
        send_frame(8'hFF, 1'b0, 0);
        check("b2b_second", {24'd0, obs_data}, 32'h0000_00FF);

        // Abort after 5 bits; clear drops the coincident bit.
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom % 2), 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("clr_busy", {31'd0, obs_busy}, 32'd0);
        check("clr_keep_data", {24'd0, obs_data}, 32'h0000_00FF);
        send_frame(8'h81, 1'b0, 2);
        check("after_clr_data", {24'd0, obs_data}, 32'h0000_0081);
        // Clear coinciding with the parity bit.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("clr_parity_nodone", {31'd0, obs_done}, 32'd0);

        // Odd parity with gaps.
        sel = 1;
        send_frame(8'h00, 1'b1, 3);
        check("odd_good_perr", {31'd0, obs_perr}, 32'd0);
        send_frame(8'h00, 1'b0, 3);
        check("odd_bad_perr", {31'd0, obs_perr}, 32'd1);

        // Random frames on every instance, with gaps.
        for (int k = 0; k < 3; k++) begin
            sel = k;
            for (int n = 0; n < 6; n++) send_frame(8'($urandom), 1'($urandom % 2), 3);
        end

        // Saturation on the 2-bit counter.
        sel = 2;
        step(1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 5; n++) begin
            w = 8'($urandom);
            send_frame(w, ~(^w), 1);
        end
        check("sat_cnt", {24'd0, obs_cnt}, 32'd3);

        // Asynchronous reset mid-frame, checked before any clock edge.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        #2;
        reset_n = 1'b1;
        send_frame(8'h5A, 1'b1, 1);
        check("post_rst_perr", {31'd0, obs_perr}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
